ez8_prog_loader: RTL and testbench

- Sequences one complete program run of `ez8_cpu`:
  - holds the core in reset;
  - streams a program image from a byte-serial host link into instruction memory through the `instr_write*` port;
  - releases the core and supervises execution until `stopped`, `error` or a timeout;
  - latches the result code and final accumulator for the host.
- Sits between the host link (UART/JTAG byte bridge) and the CPU top level.

---
 rtl/ez8_loader_pkg.sv | 20 ++
 rtl/ez8_loader_rx.sv | 42 ++++
 rtl/ez8_prog_loader.sv | 164 ++++++++++++++++
 tb/tb_ez8_prog_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ez8_loader_pkg.sv
// Shared types for the ez8 program loader: FSM state encoding and result codes.
package ez8_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_OK    = 2'd1;
  localparam logic [1:0] RES_ERR   = 2'd2;
  localparam logic [1:0] RES_FAULT = 2'd3;

endpackage

// File: rtl/ez8_loader_rx.sv
// Host byte-pair assembler: owns in_ready and pairs high/low bytes into 16-bit values.
module ez8_loader_rx
  import ez8_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        arm,
  input  logic        finish,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        take,
  output logic        pair_vld,
  output logic [15:0] pair
);

  logic       phase;
  logic [7:0] hi_q;

  assign take     = in_valid & in_ready;
  assign pair_vld = take & phase;
  assign pair     = {hi_q, in_data};

  // phase is 0 while waiting for a high byte, 1 while waiting for a low byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready <= 1'b0;
      phase    <= 1'b0;
      hi_q     <= 8'h00;
    end else if (arm) begin
      in_ready <= 1'b1;
      phase    <= 1'b0;
    end else begin
      if (finish) in_ready <= 1'b0;
      if (take) begin
        phase <= ~phase;
        if (!phase) hi_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ez8_prog_loader.sv
// Loads a program image from the host byte link into ez8 instruction memory,
// then releases the core and supervises one run until stop, error or timeout.
module ez8_prog_loader
  import ez8_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  host_pause,
  output logic                  cpu_reset,
  output logic                  cpu_pause,
  output logic [ADDR_WIDTH-1:0] instr_writeaddr,
  output logic [15:0]           instr_writedata,
  output logic                  instr_write_en,
  input  logic                  cpu_stopped,
  input  logic                  cpu_error,
  input  logic [7:0]            cpu_accum,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            result,
  output logic [7:0]            result_accum
);

  localparam int              HW        = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RESET_CYCLES);
  localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_WIDTH;
  localparam bit              TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]     TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [15:0]           remaining;
  logic [HW-1:0]         hold_cnt;
  logic [31:0]           to_cnt;

  logic        arm, finish, take, pair_vld;
  logic [15:0] pair;
  logic        last_word, n_zero, n_fault, timeout, run_exit;

  assign arm       = start && (state == S_IDLE || state == S_DONE);
  assign last_word = (remaining == 16'd1);
  assign n_zero    = (pair == 16'd0);
  assign n_fault   = ({1'b0, pair} > MAX_WORDS);
  assign timeout   = TO_EN && (to_cnt == TO_LAST);
  assign run_exit  = cpu_error || cpu_stopped || timeout;

  // the link stops accepting bytes on the low byte that ends the load
  assign finish = pair_vld &&
                  ((state == S_CNT_LO && (n_zero || n_fault)) ||
                   (state == S_DAT_LO && last_word));

  ez8_loader_rx u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .arm      (arm),
    .finish   (finish),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .take     (take),
    .pair_vld (pair_vld),
    .pair     (pair)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      waddr           <= '0;
      remaining       <= '0;
      hold_cnt        <= '0;
      to_cnt          <= '0;
      cpu_reset       <= 1'b1;
      cpu_pause       <= 1'b1;
      instr_writeaddr <= '0;
      instr_writedata <= '0;
      instr_write_en  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      result          <= RES_NONE;
      result_accum    <= 8'h00;
    end else begin
      instr_write_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_CNT_HI;
            result       <= RES_NONE;
            result_accum <= 8'h00;
            waddr        <= '0;
            to_cnt       <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        S_CNT_HI: if (take) state <= S_CNT_LO;
        S_CNT_LO: begin
          if (pair_vld) begin
            remaining <= pair;
            if (n_zero) begin
              state    <= S_HOLD;
              hold_cnt <= '0;
            end else if (n_fault) begin
              state  <= S_DONE;
              result <= RES_FAULT;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              state <= S_DAT_HI;
            end
          end
        end
        S_DAT_HI: if (take) state <= S_DAT_LO;
        S_DAT_LO: begin
          if (pair_vld) begin
            instr_write_en  <= 1'b1;
            instr_writeaddr <= waddr;
            instr_writedata <= pair;
            waddr           <= waddr + ADDR_WIDTH'(1);
            remaining       <= remaining - 16'd1;
            if (last_word) begin
              state    <= S_HOLD;
              hold_cnt <= '0;
            end else begin
              state <= S_DAT_HI;
            end
          end
        end
        S_HOLD: begin
          // HOLD lasts RESET_CYCLES+1 cycles so the core sees a clean reset after the last write
          if (hold_cnt == HOLD_LAST) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            cpu_pause <= host_pause;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_RUN: begin
          if (run_exit) begin
            state        <= S_DONE;
            result       <= cpu_error ? RES_ERR : (cpu_stopped ? RES_OK : RES_FAULT);
            result_accum <= cpu_accum;
            cpu_reset    <= 1'b1;
            cpu_pause    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else begin
            cpu_pause <= host_pause;
            if (!host_pause) to_cnt <= to_cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ez8_prog_loader.sv
// Directed bench for ez8_prog_loader: load, run supervision, timeout, fault and reset cases.
module tb_ez8_prog_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        host_pause;
  logic        cpu_reset;
  logic        cpu_pause;
  logic [11:0] instr_writeaddr;
  logic [15:0] instr_writedata;
  logic        instr_write_en;
  logic        cpu_stopped;
  logic        cpu_error;
  logic [7:0]  cpu_accum;
  logic        busy;
  logic        done;
  logic [1:0]  result;
  logic [7:0]  result_accum;

  ez8_prog_loader #(.ADDR_WIDTH(12), .RESET_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .host_pause      (host_pause),
    .cpu_reset       (cpu_reset),
    .cpu_pause       (cpu_pause),
    .instr_writeaddr (instr_writeaddr),
    .instr_writedata (instr_writedata),
    .instr_write_en  (instr_write_en),
    .cpu_stopped     (cpu_stopped),
    .cpu_error       (cpu_error),
    .cpu_accum       (cpu_accum),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .result_accum    (result_accum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_cyc = -1;
  logic prev_cr = 1'b1;
  logic [11:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (instr_write_en) begin
      wa.push_back(instr_writeaddr);
      wd.push_back(instr_writedata);
      wc.push_back(cyc);
    end
    if (prev_cr && !cpu_reset) fall_cyc = cyc;
    prev_cr = cpu_reset;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hs_bound", 32'(n < 50), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (cpu_reset && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("run_bound", 32'(n < 50), 32'd1);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  initial begin
    int n, k;
    reset_n = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    host_pause = 1'b0; cpu_stopped = 1'b0; cpu_error = 1'b0; cpu_accum = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_cpu_pause", 32'(cpu_pause), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wen", 32'(instr_write_en), 32'd0);
    chk("rst_waddr", 32'(instr_writeaddr), 32'd0);
    chk("rst_wdata", 32'(instr_writedata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_accum", 32'(result_accum), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // full-rate load of three words, then clean stop with accum 0
    pulse_start();
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    send_word(16'd3, 0);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'h0001, 0);
    chk("t1_wen_after_last", 32'(instr_write_en), 32'd1);
    chk("t1_ready_off", 32'(in_ready), 32'd0);
    wait_run();
    chk("t1_nwrites", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      chk("t1_a0", 32'(wa[0]), 32'h000); chk("t1_d0", 32'(wd[0]), 32'h1234);
      chk("t1_a1", 32'(wa[1]), 32'h001); chk("t1_d1", 32'(wd[1]), 32'hABCD);
      chk("t1_a2", 32'(wa[2]), 32'h002); chk("t1_d2", 32'(wd[2]), 32'h0001);
      chk("t1_rate", 32'(wc[1] - wc[0]), 32'd2);
      chk("t1_release_lat", 32'(fall_cyc - wc[2]), 32'd5);
    end
    chk("t1_run_pause", 32'(cpu_pause), 32'd0);
    chk("t1_run_busy", 32'(busy), 32'd1);
    cpu_accum = 8'h00; cpu_stopped = 1'b1;
    @(negedge clk);
    cpu_stopped = 1'b0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_result", 32'(result), 32'd1);
    chk("t1_accum", 32'(result_accum), 32'h00);
    chk("t1_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t1_pause_done", 32'(cpu_pause), 32'd1);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // throttled link, ignored start mid-load, simultaneous error+stop
    clear_log();
    pulse_start();
    chk("t2_restart_result", 32'(result), 32'd0);
    send_word(16'd2, 1);
    send_byte(8'hBE, 1);
    pulse_start();
    send_byte(8'hEF, 1);
    send_word(16'h0F0F, 1);
    wait_run();
    chk("t2_nwrites", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("t2_a0", 32'(wa[0]), 32'h000); chk("t2_d0", 32'(wd[0]), 32'hBEEF);
      chk("t2_a1", 32'(wa[1]), 32'h001); chk("t2_d1", 32'(wd[1]), 32'h0F0F);
    end
    cpu_accum = 8'h5A; cpu_error = 1'b1; cpu_stopped = 1'b1;
    @(negedge clk);
    cpu_error = 1'b0; cpu_stopped = 1'b0;
    chk("t2_result", 32'(result), 32'd2);
    chk("t2_accum", 32'(result_accum), 32'h5A);

    // N=0 goes straight to HOLD; timeout of 16 with 4 paused cycles
    clear_log();
    pulse_start();
    send_word(16'd0, 0);
    k = cyc;
    wait_run();
    chk("t3_release_lat", 32'(fall_cyc - k), 32'd5);
    cpu_accum = 8'h77;
    n = 0;
    while (!cpu_reset && n < 100) begin
      if (n == 0) host_pause = 1'b1;
      if (n == 2) chk("t3_pause_fwd", 32'(cpu_pause), 32'd1);
      if (n == 4) host_pause = 1'b0;
      if (n == 6) chk("t3_unpause_fwd", 32'(cpu_pause), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("t3_run_cycles", 32'(n), 32'd20);
    chk("t3_result", 32'(result), 32'd3);
    chk("t3_accum", 32'(result_accum), 32'h77);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_nwrites", 32'(wa.size()), 32'd0);

    // oversized header faults without writing
    clear_log();
    pulse_start();
    send_word(16'h1001, 0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_result", 32'(result), 32'd3);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_nwrites", 32'(wa.size()), 32'd0);

    // maximum image size fills the whole memory
    clear_log();
    pulse_start();
    send_word(16'h1000, 0);
    for (int i = 0; i < 4096; i++) send_word(16'(i), 0);
    wait_run();
    chk("t5_nwrites", 32'(wa.size()), 32'd4096);
    if (wa.size() == 4096) begin
      chk("t5_a_first", 32'(wa[0]), 32'h000);
      chk("t5_a_last", 32'(wa[4095]), 32'hFFF);
      chk("t5_d_last", 32'(wd[4095]), 32'h0FFF);
      chk("t5_span", 32'(wc[4095] - wc[0]), 32'd8190);
    end
    cpu_accum = 8'hC3; cpu_stopped = 1'b1;
    @(negedge clk);
    cpu_stopped = 1'b0;
    chk("t5_result", 32'(result), 32'd1);
    chk("t5_accum", 32'(result_accum), 32'hC3);

    // reset in the middle of a data word, then a fresh load
    clear_log();
    pulse_start();
    send_word(16'd2, 0);
    send_byte(8'hAA, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_result", 32'(result), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_nwrites", 32'(wa.size()), 32'd0);
    pulse_start();
    send_word(16'd1, 0);
    send_word(16'h4321, 0);
    wait_run();
    chk("t6_reload_n", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("t6_reload_a", 32'(wa[0]), 32'h000);
      chk("t6_reload_d", 32'(wd[0]), 32'h4321);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
